// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in clk50m cycles
//   clk50m  system clock          rst_n  async active-low reset
//   en      0 forces idle         pwm_in asynchronous PWM input
//   per/hi  last period / high time, valid one-cycle update pulse
//   stuck   no rising edge seen for 2^W-1 clocks
module pwm_capture #(
  parameter int W = 5
) (
  input  logic         clk50m,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] per,
  output logic [W-1:0] hi,
  output logic         valid,
  output logic         stuck
);
  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;
  localparam logic [W-1:0] TMO = {{(W-1){1'b1}}, 1'b0};
  state_t       r_state;
  logic         r_s1, r_s2, r_s3;
  logic [W-1:0] r_cnt, r_hi_tmp, r_per, r_hi;
  logic         r_valid, r_stuck;
  logic         w_rise, w_fall, w_tmo;
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  // a rise on the last count is a legal full-scale period, so it masks the timeout
  assign w_tmo  = (r_state != IDLE) && (r_cnt == TMO) && !w_rise;
  assign per    = r_per;
  assign hi     = r_hi;
  assign valid  = r_valid;
  assign stuck  = r_stuck;
  always_ff @(posedge clk50m or negedge rst_n)
    if (!rst_n) begin
      {r_s1, r_s2, r_s3} <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hi_tmp <= '0;
      r_per    <= '0;
      r_hi     <= '0;
      r_valid  <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, pwm_in};
      r_valid <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE) begin
        r_state <= SYNC;
        r_cnt   <= '0;
      end else if (w_rise) begin
        // only a rise seen from LOW closes a period that was measured from its start
        r_state <= HIGH;
        r_cnt   <= '0;
        if (r_state == LOW) begin
          r_per   <= r_cnt + 1'b1;
          r_hi    <= r_hi_tmp;
          r_valid <= 1'b1;
          r_stuck <= 1'b0;
        end
      end else if (w_tmo) begin
        r_state <= SYNC;
        r_cnt   <= '0;
        r_per   <= '1;
        r_hi    <= r_s2 ? '1 : '0;
        r_valid <= 1'b1;
        r_stuck <= 1'b1;
      end else if (w_fall && r_state == HIGH) begin
        r_state  <= LOW;
        r_hi_tmp <= r_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture driven by directed PWM waveforms
module tb_pwm_capture;
  logic       clk50m, rst_n, en, pwm_in;
  logic [4:0] per, hi;
  logic       valid, stuck;
  pwm_capture #(.W(5)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .per(per), .hi(hi), .valid(valid), .stuck(stuck)
  );
  initial clk50m = 1'b0;
  always #5 clk50m = ~clk50m;
  typedef struct {int p; int h; int s;} rep_t;
  rep_t sb[$];
  rep_t e;
  int   checks = 0;
  int   errors = 0;
  int   last_p = 0;
  int   last_h = 0;
  logic prev_valid = 1'b0;
  logic m_prev = 1'b0;
  logic m_armed = 1'b0;
  logic m_aligned = 1'b0;
  int   m_gap = 0;
  int   m_hlen = 0;
  int   m_since = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask
  // input-side model: a report closes each rise-to-rise interval that began while tracking;
  // 31 input cycles without a rise yield a stuck report
  task automatic step(input logic v);
    pwm_in = v;
    if (!en) begin
      m_armed   = 1'b0;
      m_aligned = 1'b0;
    end else if (v && !m_prev) begin
      if (m_armed) sb.push_back('{m_gap, m_hlen, 0});
      m_armed   = 1'b1;
      m_aligned = 1'b1;
      m_gap     = 1;
      m_hlen    = 1;
      m_since   = 0;
    end else begin
      m_gap++;
      m_hlen += int'(v);
      m_since++;
      if (m_aligned && m_since == 31) begin
        sb.push_back('{31, v ? 31 : 0, 1});
        m_armed = 1'b0;
        m_since = 0;
      end
    end
    m_prev = v;
    @(posedge clk50m);
    #1;
  endtask
  task automatic pwm(input int p, input int h);
    for (int i = 0; i < p; i++) step(i < h);
  endtask
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask
  always @(negedge clk50m) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid per %0d hi %0d stuck %0d at %0t", per, hi, stuck, $time);
      end else begin
        e = sb.pop_front();
        chk("report_per", int'(per), e.p);
        chk("report_hi", int'(hi), e.h);
        chk("report_stuck", int'(stuck), e.s);
        last_p = e.p;
        last_h = e.h;
      end
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_pulse actual 2 consecutive required 1 at %0t", $time);
      end
    end
    prev_valid = valid;
  end
  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    pwm_in = 1'b0;
    #1;
    chk("rst_per", int'(per), 0);
    chk("rst_hi", int'(hi), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    repeat (3) @(posedge clk50m);
    #1;
    rst_n = 1'b1;
    hold(0, 5);
    repeat (5) pwm(10, 4);
    pwm(6, 4);
    repeat (4) pwm(31, 18);
    hold(0, 100);
    repeat (3) pwm(8, 2);
    hold(1, 100);
    hold(0, 3);
    repeat (4) pwm(8, 2);
    repeat (3) pwm(10, 4);
    hold(1, 4);
    hold(0, 3);
    en = 1'b0;
    hold(0, 3);
    pwm(10, 4);
    hold(1, 4);
    hold(0, 3);
    chk("hold_per", int'(per), last_p);
    chk("hold_hi", int'(hi), last_h);
    en = 1'b1;
    hold(0, 3);
    repeat (3) pwm(10, 4);
    hold(1, 4);
    hold(0, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_per", int'(per), 0);
    chk("mid_rst_hi", int'(hi), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_stuck", int'(stuck), 0);
    m_prev    = 1'b0;
    m_armed   = 1'b0;
    m_aligned = 1'b0;
    hold(0, 3);
    rst_n = 1'b1;
    hold(0, 2);
    repeat (4) pwm(10, 4);
    hold(0, 10);
    chk("pending_reports", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
